// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
//   Shares the frame-buffer Avalon write port between N_REQ drawing clients.
//   Each client asks for a solid rectangle fill. Requests are granted
//   round-robin, the rectangle is clipped to the screen, and the block then
//   streams one pixel write per accepted bus cycle.
//
// Ports
//   dataclock    system clock (the only clock)
//   reset        synchronous, active-high
//   req          per-client level request, held until the matching ack
//   rect_x/y/w/h packed per-client rectangle origin and size
//   rect_colour  packed per-client RGB888 fill colour
//   ack          one-cycle completion pulse per client
//   busy         high whenever the engine is not idle
//   address      frame-buffer word address (y*H_RES + x)
//   writedata    {8'h00, colour}
//   write        write strobe
//   waitrequest  fabric stall; a write is accepted when write=1 and waitrequest=0
module vga_draw_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned H_RES = 160,
  parameter int unsigned V_RES = 120
) (
  input  logic                  dataclock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*8-1:0]    rect_x,
  input  logic [N_REQ*7-1:0]    rect_y,
  input  logic [N_REQ*8-1:0]    rect_w,
  input  logic [N_REQ*7-1:0]    rect_h,
  input  logic [N_REQ*24-1:0]   rect_colour,
  output logic [N_REQ-1:0]      ack,
  output logic                  busy,
  output logic [15:0]           address,
  output logic [31:0]           writedata,
  output logic                  write,
  input  logic                  waitrequest
);

  localparam int unsigned GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [8:0]  XLIM = 9'(H_RES);
  localparam logic [7:0]  YLIM = 8'(V_RES);
  localparam logic [GW-1:0] LAST = GW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, CLIP, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [GW-1:0] last_grant, grant, pick, idx;
  logic          found;

  logic [7:0]  x0, w, cur_x;
  logic [6:0]  y0, h, cur_y;
  logic [23:0] colour;
  logic [8:0]  x_end;
  logic [7:0]  y_end;

  logic [7:0]  sel_x, sel_w;
  logic [6:0]  sel_y, sel_h;
  logic [23:0] sel_c;

  logic [8:0]  x_sum, x_end_c;
  logic [7:0]  y_sum, y_end_c;
  logic        empty, accept, row_last, last_pixel;
  logic [15:0] addr_lin;

  // Round-robin search: first set req bit starting at last_grant+1, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = GW'((32'(last_grant) + i) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Unpack the rectangle fields of the client being granted.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_w = '0;
    sel_h = '0;
    sel_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick == GW'(i)) begin
        sel_x = rect_x[8*i +: 8];
        sel_y = rect_y[7*i +: 7];
        sel_w = rect_w[8*i +: 8];
        sel_h = rect_h[7*i +: 7];
        sel_c = rect_colour[24*i +: 24];
      end
    end
  end

  // Clip arithmetic is one bit wider than the operands so the sum cannot wrap.
  always_comb begin
    x_sum   = {1'b0, x0} + {1'b0, w};
    y_sum   = {1'b0, y0} + {1'b0, h};
    x_end_c = (x_sum > XLIM) ? XLIM : x_sum;
    y_end_c = (y_sum > YLIM) ? YLIM : y_sum;
    empty   = (w == '0) || (h == '0) || ({1'b0, x0} >= XLIM) || ({1'b0, y0} >= YLIM);
  end

  always_comb begin
    accept     = (state == WRITE) && !waitrequest;
    row_last   = ({1'b0, cur_x} + 9'd1) >= x_end;
    last_pixel = row_last && (({1'b0, cur_y} + 8'd1) == y_end);
    addr_lin   = 16'(cur_y) * 16'(H_RES) + 16'(cur_x);
  end

  always_ff @(posedge dataclock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bus outputs depend on the state register only, so they stay frozen while
  // waitrequest stalls the WRITE state.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    write     = 1'b0;
    address   = '0;
    writedata = '0;
    ack       = '0;
    case (state)
      IDLE:  if (found) state_nxt = CLIP;
      CLIP:  state_nxt = empty ? DONE : WRITE;
      WRITE: begin
        write     = 1'b1;
        address   = addr_lin;
        writedata = {8'h00, colour};
        if (accept && last_pixel) state_nxt = DONE;
      end
      DONE: begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
          if (grant == GW'(i)) ack[i] = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dataclock) begin
    if (reset) begin
      last_grant <= LAST;
      grant      <= '0;
      x0         <= '0;
      y0         <= '0;
      w          <= '0;
      h          <= '0;
      colour     <= '0;
      x_end      <= '0;
      y_end      <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= pick;
            x0     <= sel_x;
            y0     <= sel_y;
            w      <= sel_w;
            h      <= sel_h;
            colour <= sel_c;
          end
        end
        CLIP: begin
          x_end <= x_end_c;
          y_end <= y_end_c;
          cur_x <= x0;
          cur_y <= y0;
        end
        WRITE: begin
          if (accept) begin
            if (!row_last) begin
              cur_x <= cur_x + 8'd1;
            end else begin
              cur_x <= x0;
              cur_y <= cur_y + 7'd1;
            end
          end
        end
        DONE:    last_grant <= grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter
//   Directed bench for vga_draw_arbiter. Stimulus pushes the expected pixel
//   writes and acks (with their cycle numbers) into queues; a forked monitor
//   pops and compares whenever the DUT presents a write or an ack.
module tb_vga_draw_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] rect_x;
  logic [20:0] rect_y;
  logic [23:0] rect_w;
  logic [20:0] rect_h;
  logic [71:0] rect_colour;
  logic [2:0]  ack;
  logic        busy;
  logic [15:0] address;
  logic [31:0] writedata;
  logic        write;
  logic        waitrequest;

  vga_draw_arbiter #(.N_REQ(3), .H_RES(160), .V_RES(120)) dut (
    .dataclock   (clk),
    .reset       (reset),
    .req         (req),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .rect_colour (rect_colour),
    .ack         (ack),
    .busy        (busy),
    .address     (address),
    .writedata   (writedata),
    .write       (write),
    .waitrequest (waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] a; logic [31:0] d; int c; } wr_t;
  typedef struct { logic [2:0] v; int c; } ack_t;
  wr_t  exp_wr[$];
  ack_t exp_ack[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_wr(input int x, input int y, input logic [23:0] col, input int c);
    wr_t e;
    e.a = 16'(y * 160 + x);
    e.d = {8'h00, col};
    e.c = c;
    exp_wr.push_back(e);
  endtask

  task automatic push_ack(input logic [2:0] v, input int c);
    ack_t e;
    e.v = v;
    e.c = c;
    exp_ack.push_back(e);
  endtask

  task automatic set_rect(input int c, input logic [7:0] x, input logic [6:0] y,
                          input logic [7:0] w, input logic [6:0] h, input logic [23:0] col);
    rect_x[8*c +: 8]       = x;
    rect_y[7*c +: 7]       = y;
    rect_w[8*c +: 8]       = w;
    rect_h[7*c +: 7]       = h;
    rect_colour[24*c +: 24] = col;
  endtask

  // Client side of the handshake: drop each req bit as soon as its ack is seen.
  task automatic wait_acks(input int n, input int budget);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        req = req & ~ack;
        got++;
      end
    end
    if (got < n) check("ack_timeout", 64'(got), 64'(n));
  endtask

  task automatic monitor();
    wr_t  w;
    ack_t a;
    forever begin
      @(negedge clk);
      if (write && waitrequest) begin
        if (exp_wr.size() > 0) begin
          check("stall_addr", 64'(address), 64'(exp_wr[0].a));
          check("stall_data", 64'(writedata), 64'(exp_wr[0].d));
        end else begin
          check("unexpected_write", 64'(write), 64'(0));
        end
      end
      if (write && !waitrequest) begin
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          check("wr_addr", 64'(address), 64'(w.a));
          check("wr_data", 64'(writedata), 64'(w.d));
          if (w.c >= 0) check("wr_cycle", 64'(cyc), 64'(w.c));
        end else begin
          check("unexpected_write", 64'(write), 64'(0));
        end
      end
      if (ack != 3'b000) begin
        if (exp_ack.size() > 0) begin
          a = exp_ack.pop_front();
          check("ack_vec", 64'(ack), 64'(a.v));
          if (a.c >= 0) check("ack_cycle", 64'(cyc), 64'(a.c));
        end else begin
          check("unexpected_ack", 64'(ack), 64'(0));
        end
      end
    end
  endtask

  // Three 1x1 rectangles at (0,0),(1,0),(2,0); round-robin order from last_grant=2.
  task automatic rr_three();
    @(negedge clk);
    set_rect(0, 8'd0, 7'd0, 8'd1, 7'd1, 24'h111111);
    set_rect(1, 8'd1, 7'd0, 8'd1, 7'd1, 24'h222222);
    set_rect(2, 8'd2, 7'd0, 8'd1, 7'd1, 24'h333333);
    t = cyc;
    push_wr(0, 0, 24'h111111, t + 2);  push_ack(3'b001, t + 3);
    push_wr(1, 0, 24'h222222, t + 6);  push_ack(3'b010, t + 7);
    push_wr(2, 0, 24'h333333, t + 10); push_ack(3'b100, t + 11);
    req = 3'b111;
    wait_acks(3, 40);
  endtask

  initial begin
    reset       = 1'b1;
    req         = '0;
    rect_x      = '0;
    rect_y      = '0;
    rect_w      = '0;
    rect_h      = '0;
    rect_colour = '0;
    waitrequest = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_write", 64'(write), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_address", 64'(address), 64'(0));
    check("rst_writedata", 64'(writedata), 64'(0));
    reset = 1'b0;

    // Round-robin: two full rounds, then 0 alone followed by {0,2} -> 2 first.
    rr_three();
    rr_three();
    @(negedge clk);
    t = cyc;
    push_wr(0, 0, 24'h111111, t + 2); push_ack(3'b001, t + 3);
    req = 3'b001;
    wait_acks(1, 20);
    @(negedge clk);
    t = cyc;
    push_wr(2, 0, 24'h333333, t + 2); push_ack(3'b100, t + 3);
    push_wr(0, 0, 24'h111111, t + 6); push_ack(3'b001, t + 7);
    req = 3'b101;
    wait_acks(2, 30);

    // Reset during the 2nd write of a 4x4 fill; last_grant is 0 here, so only
    // a reinitialised last_grant lets client 0 win over client 1 afterwards.
    @(negedge clk);
    set_rect(0, 8'd20, 7'd10, 8'd4, 7'd4, 24'hABCDEF);
    set_rect(1, 8'd50, 7'd50, 8'd1, 7'd1, 24'h0000FF);
    t = cyc;
    push_wr(20, 10, 24'hABCDEF, t + 2);
    push_wr(21, 10, 24'hABCDEF, t + 3);
    req = 3'b001;
    repeat (3) @(negedge clk);
    req   = 3'b011;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_write", 64'(write), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_ack", 64'(ack), 64'(0));
    t = cyc;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        push_wr(20 + x, 10 + y, 24'hABCDEF, t + 2 + y * 4 + x);
    push_ack(3'b001, t + 18);
    push_wr(50, 50, 24'h0000FF, t + 21);
    push_ack(3'b010, t + 22);
    reset = 1'b0;
    wait_acks(2, 60);

    // Single 2x2 fill.
    @(negedge clk);
    set_rect(0, 8'd10, 7'd5, 8'd2, 7'd2, 24'hFF0000);
    t = cyc;
    push_wr(10, 5, 24'hFF0000, t + 2);
    push_wr(11, 5, 24'hFF0000, t + 3);
    push_wr(10, 6, 24'hFF0000, t + 4);
    push_wr(11, 6, 24'hFF0000, t + 5);
    push_ack(3'b001, t + 6);
    req = 3'b001;
    wait_acks(1, 20);

    // Clipping at the bottom-right corner.
    @(negedge clk);
    set_rect(1, 8'd158, 7'd119, 8'd4, 7'd3, 24'h00FF00);
    t = cyc;
    push_wr(158, 119, 24'h00FF00, t + 2);
    push_wr(159, 119, 24'h00FF00, t + 3);
    push_ack(3'b010, t + 4);
    req = 3'b010;
    wait_acks(1, 20);

    // Empty rectangles: w=0, x0 off-screen, y0 off-screen.
    @(negedge clk);
    set_rect(2, 8'd5, 7'd5, 8'd0, 7'd3, 24'h0F0F0F);
    t = cyc;
    push_ack(3'b100, t + 2);
    req = 3'b100;
    wait_acks(1, 20);
    @(negedge clk);
    set_rect(2, 8'd200, 7'd5, 8'd5, 7'd1, 24'h0F0F0F);
    t = cyc;
    push_ack(3'b100, t + 2);
    req = 3'b100;
    wait_acks(1, 20);
    @(negedge clk);
    set_rect(2, 8'd5, 7'd125, 8'd2, 7'd2, 24'h0F0F0F);
    t = cyc;
    push_ack(3'b100, t + 2);
    req = 3'b100;
    wait_acks(1, 20);

    // Stall of 3 cycles on the 2nd pixel of a 3x1 row.
    @(negedge clk);
    set_rect(0, 8'd30, 7'd40, 8'd3, 7'd1, 24'h123456);
    t = cyc;
    push_wr(30, 40, 24'h123456, t + 2);
    push_wr(31, 40, 24'h123456, t + 6);
    push_wr(32, 40, 24'h123456, t + 7);
    push_ack(3'b001, t + 8);
    req = 3'b001;
    repeat (3) @(posedge clk);
    #1 waitrequest = 1'b1;
    repeat (3) @(posedge clk);
    #1 waitrequest = 1'b0;
    wait_acks(1, 20);

    repeat (2) @(negedge clk);
    check("wr_queue_drained", 64'(exp_wr.size()), 64'(0));
    check("ack_queue_drained", 64'(exp_ack.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
